// File: rtl/dmac_pkg.sv
// dmac_pkg: constants shared across the DMA controller data path.
// The write buffer and the write engine both take their burst length and
// buffer depth from here, so the reserve/release count widths agree.
package dmac_pkg;

    // Longest burst the read and write engines issue, in beats.
    localparam int DEFAULT_MAX_BURST_LEN = 16;

    // Number of beats the staging buffer between read and write engine holds.
    localparam int DEFAULT_BUF_DEPTH = 32;

endpackage : dmac_pkg

// File: rtl/dmac_sync_fifo.sv
// dmac_sync_fifo: single-clock FIFO with first-word-fall-through output.
// Storage is a flop array that is read combinationally, so a beat pushed at
// one edge is visible on pop_data right after that edge.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   push, push_data      write strobe and data (ignored when full)
//   pop                  read strobe (ignored when empty)
//   pop_data             head entry, valid while !empty
//   full, empty, level   occupancy status
module dmac_sync_fifo #(
    parameter int DATA_WD = 32,
    parameter int DEPTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_WD-1:0]       push_data,
    input  logic                     pop,
    output logic [DATA_WD-1:0]       pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [DATA_WD-1:0] mem_q [DEPTH];
    logic               push_ok;
    logic               pop_ok;

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign level = wr_ptr_q - rd_ptr_q;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Data entries carry no reset; stale contents are never visible because
    // empty masks them.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
                mem_q[gi] <= push_data;
            end
        end
    end

endmodule : dmac_sync_fifo

// File: rtl/dmac_write_buffer.sv
// dmac_write_buffer: staging buffer between the DMA read engine and the
// write initiator. Beats from the read channel land in a FIFO and are shown
// first-word-fall-through to the write initiator. A usage counter tracks
// space the read engine has reserved but the write initiator has not yet
// released, so a read burst is only issued when it is sure to fit.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rsv_valid/count/ready    reservation request and combinational grant
//   in_valid/data/ready      read-data beats into the buffer
//   data_out_valid/data/rdy  beats out to the write initiator
//   buf_dec_usage_valid/cnt  release of committed beats
//   usage, level             reserved-unreleased beats, stored beats
//   err                      sticky protocol-violation flag
module dmac_write_buffer
    import dmac_pkg::*;
#(
    parameter int DATA_WD       = 32,
    parameter int MAX_BURST_LEN = DEFAULT_MAX_BURST_LEN,
    parameter int DEPTH         = DEFAULT_BUF_DEPTH,
    parameter int CNT_WD        = $clog2(MAX_BURST_LEN) + 2,
    parameter int USE_WD        = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rsv_valid,
    input  logic [CNT_WD-1:0]  rsv_count,
    output logic               rsv_ready,
    input  logic               in_valid,
    input  logic [DATA_WD-1:0] in_data,
    output logic               in_ready,
    output logic               data_out_valid,
    output logic [DATA_WD-1:0] data_out,
    input  logic               data_out_ready,
    input  logic               buf_dec_usage_valid,
    input  logic [CNT_WD-1:0]  buf_dec_usage_count,
    output logic [USE_WD-1:0]  usage,
    output logic [USE_WD-1:0]  level,
    output logic               err
);

    // Usage arithmetic runs one bit wider than the counter so that
    // usage + rsv_count can never wrap before it is compared.
    localparam logic [USE_WD:0] MAX_EXT   = (USE_WD + 1)'(MAX_BURST_LEN);
    localparam logic [USE_WD:0] DEPTH_EXT = (USE_WD + 1)'(DEPTH);

    logic [USE_WD-1:0] usage_q, usage_d;
    logic              err_q, err_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push_acc;
    logic              pop_acc;

    logic [USE_WD:0]   usage_ext;
    logic [USE_WD:0]   rsv_ext;
    logic [USE_WD:0]   dec_ext;
    logic [USE_WD:0]   sum_ext;
    logic [USE_WD:0]   diff_ext;
    logic              rsv_len_ok;
    logic              grant;

    dmac_sync_fifo #(
        .DATA_WD (DATA_WD),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_acc),
        .push_data (in_data),
        .pop       (pop_acc),
        .pop_data  (data_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Outputs are forced to their idle values while rst is held, before the
    // registered state has been cleared by the first reset edge.
    assign in_ready       = rst || !fifo_full;
    assign data_out_valid = !rst && !fifo_empty;
    assign push_acc       = in_valid && in_ready;
    assign pop_acc        = data_out_valid && data_out_ready;
    assign rsv_ready      = grant;
    assign usage          = usage_q;
    assign err            = err_q;

    always_comb begin
        usage_ext = {1'b0, usage_q};
        rsv_ext   = '0;
        dec_ext   = '0;
        rsv_ext[CNT_WD-1:0] = rsv_count;
        dec_ext[CNT_WD-1:0] = buf_dec_usage_count;

        rsv_len_ok = (rsv_ext <= MAX_EXT);
        // Grant sees only the registered usage; a release in the same cycle
        // is credited from the next cycle on.
        grant = !rst && rsv_valid && rsv_len_ok && ((usage_ext + rsv_ext) <= DEPTH_EXT);

        sum_ext  = grant ? (usage_ext + rsv_ext) : usage_ext;
        diff_ext = sum_ext - dec_ext;

        usage_d = sum_ext[USE_WD-1:0];
        err_d   = err_q;

        if (buf_dec_usage_valid) begin
            if (dec_ext > sum_ext) begin
                usage_d = '0;
                err_d   = 1'b1;
            end else begin
                usage_d = diff_ext[USE_WD-1:0];
            end
        end

        if (rsv_valid && !rsv_len_ok) begin
            err_d = 1'b1;
        end

        // Every stored beat is already reserved, so a push arriving when
        // level has caught up with usage lands in space nobody reserved.
        if (push_acc && (level == usage_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            usage_q <= '0;
            err_q   <= 1'b0;
        end else begin
            usage_q <= usage_d;
            err_q   <= err_d;
        end
    end

endmodule : dmac_write_buffer
